// File: rtl/ram_controlador_pkg.sv
// Shared encodings and default geometry for the ram_controlador front-end.
package ram_controlador_pkg;

    localparam int DEPTH_DEF = 11;
    localparam int AW_DEF    = 8;
    localparam int DW_DEF    = 8;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD      = 3'd1;
    localparam logic [2:0] ST_WR_SET  = 3'd2;
    localparam logic [2:0] ST_WR_EN   = 3'd3;
    localparam logic [2:0] ST_WR_HOLD = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;

endpackage

// File: rtl/ram_ctrl_secuenciador.sv
// Fill address counter: cleared on load, advanced on step, flags the last RAM entry.
module ram_ctrl_secuenciador #(
    parameter int DEPTH = 11,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    output logic [AW-1:0] nxt,
    output logic          last
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [AW-1:0] cnt;

    // Stepping stops at the terminal address, so the counter never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign nxt  = cnt + 1'b1;
    assign last = (cnt == LAST_ADDR);

endmodule

// File: rtl/ram_controlador.sv
// Valid/ready command front-end for the 8-bit asynchronous RAM: read, write and fill
// with a registered, glitch-free level-sensitive write enable.
module ram_controlador
    import ram_controlador_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_en,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [2:0]    state;
    logic          fill_q;
    logic          accept;
    logic          cmd_err;
    logic          seq_step;
    logic          seq_last;
    logic [AW-1:0] seq_nxt;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign cmd_err   = (req_op == OP_RSVD) ||
                       (((req_op == OP_READ) || (req_op == OP_WRITE)) && (req_addr > LAST_ADDR));
    assign seq_step  = (state == ST_WR_HOLD) && fill_q;

    ram_ctrl_secuenciador #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_secuenciador (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .step (seq_step),
        .nxt  (seq_nxt),
        .last (seq_last)
    );

    // mem_en is a flop output and only rises with mem_addr/mem_wdata already settled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            fill_q    <= 1'b0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        fill_q    <= (req_op == OP_FILL);
                        mem_wdata <= req_wdata;
                        if (cmd_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= ST_RESP;
                        end else begin
                            mem_addr <= (req_op == OP_FILL) ? '0 : req_addr;
                            state    <= (req_op == OP_READ) ? ST_RD : ST_WR_SET;
                        end
                    end
                end
                ST_RD: begin
                    rsp_rdata <= mem_rdata;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_WR_SET: begin
                    mem_en <= 1'b1;
                    state  <= ST_WR_EN;
                end
                ST_WR_EN: begin
                    mem_en <= 1'b0;
                    state  <= ST_WR_HOLD;
                end
                ST_WR_HOLD: begin
                    if (fill_q && !seq_last) begin
                        mem_addr <= seq_nxt;
                        state    <= ST_WR_SET;
                    end else begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    mem_en <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_controlador.sv
// Bench for ram_controlador with an attached asynchronous RAM model and a reference memory.
module tb_ram_controlador;

    localparam int DEPTH = 11;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, mem_en;
    logic [1:0] req_op;
    logic [7:0] req_addr, req_wdata, rsp_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [7:0] ram     [0:DEPTH-1];
    logic [7:0] ref_mem [0:DEPTH-1];

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] en_q[$];
    int         en_cycles = 0;
    logic       en_prev   = 1'b0;

    always #5 clk = ~clk;

    ram_controlador dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_en    (mem_en),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [7:0] preload(input int i);
        if (i < 9) return 8'(90 - 10 * i);
        return 8'(100 + (i - 9));
    endfunction

    // Asynchronous RAM: level-sensitive write while EN is high, combinational read.
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = preload(i);
        forever begin
            @(mem_en or mem_addr or mem_wdata);
            if (mem_en && mem_addr <= 8'd10) ram[mem_addr[3:0]] = mem_wdata;
        end
    end
    assign mem_rdata = (mem_addr <= 8'd10) ? ram[mem_addr[3:0]] : 8'h00;

    always @(negedge clk) begin
        if (mem_en) begin
            en_cycles = en_cycles + 1;
            if (!en_prev) en_q.push_back(mem_addr);
        end
        en_prev = mem_en;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] addr,
                          input logic [7:0] data, input bit ack);
        int         base_q, base_c, lat, n, exp_lat, exp_n;
        bit         exp_err;
        logic [7:0] exp_rd;
        exp_err = (op == 2'b11) || (op != 2'b10 && addr > 8'd10);
        exp_rd  = (op == 2'b00 && !exp_err) ? ref_mem[addr[3:0]] : 8'h00;
        exp_lat = exp_err ? 0 : (op == 2'b00 ? 1 : (op == 2'b01 ? 3 : 3 * DEPTH));
        exp_n   = (exp_err || op == 2'b00) ? 0 : (op == 2'b01 ? 1 : DEPTH);
        base_q  = en_q.size();
        base_c  = en_cycles;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = data;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        check("req_ready_wait", (n < 50) ? 1 : 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check("rsp_latency", lat, exp_lat);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", rsp_err, exp_err);
        check("req_ready_busy", req_ready, 0);
        check("en_pulses", en_q.size() - base_q, exp_n);
        check("en_cycles", en_cycles - base_c, exp_n);
        for (int i = 0; i < exp_n && (base_q + i) < en_q.size(); i++)
            check("en_addr", en_q[base_q + i], (op == 2'b01) ? addr : 8'(i));
        if (!exp_err && op == 2'b01) ref_mem[addr[3:0]] = data;
        if (!exp_err && op == 2'b10) for (int i = 0; i < DEPTH; i++) ref_mem[i] = data;
        if (ack) begin
            @(posedge clk); #1;
            check("rsp_clear", rsp_valid, 0);
            check("req_ready_back", req_ready, 1);
        end
    endtask

    initial begin
        int base_c, base_q;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = preload(i);
        rst = 1'b1; rsp_ready = 1'b1; req_valid = 1'b0;
        req_op = 2'b00; req_addr = 8'h00; req_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        @(negedge clk); rst = 1'b0;

        do_cmd(2'b00, 8'd3, 8'h00, 1'b1);
        check("read3_value", rsp_rdata, 60);
        do_cmd(2'b01, 8'd5, 8'hAA, 1'b1);
        do_cmd(2'b00, 8'd5, 8'h00, 1'b1);
        check("read5_value", rsp_rdata, 8'hAA);

        do_cmd(2'b00, 8'd11, 8'h00, 1'b1);
        do_cmd(2'b11, 8'd1, 8'h77, 1'b1);
        for (int i = 0; i < DEPTH; i++) check("ram_after_err", ram[i], ref_mem[i]);

        do_cmd(2'b10, 8'd0, 8'h00, 1'b1);
        for (int i = 0; i < DEPTH; i++) do_cmd(2'b00, 8'(i), 8'h00, 1'b1);

        for (int k = 0; k < 25; k++)
            do_cmd(2'($urandom_range(0, 3)), 8'($urandom_range(0, 13)), 8'($urandom), 1'b1);

        // Response back-pressure with a stray request in the window.
        rsp_ready = 1'b0;
        base_c = en_cycles;
        do_cmd(2'b00, 8'd2, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) begin
                req_valid = 1'b1; req_op = 2'b01; req_addr = 8'd2; req_wdata = 8'hEE;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_rdata", rsp_rdata, ref_mem[2]);
            check("bp_rsp_err", rsp_err, 0);
            check("bp_req_ready", req_ready, 0);
        end
        @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", rsp_valid, 0);
        check("bp_no_write", en_cycles - base_c, 0);
        do_cmd(2'b00, 8'd2, 8'h00, 1'b1);

        for (int i = 0; i < DEPTH; i++) do_cmd(2'b01, 8'(i), 8'(8'hC0 + i), 1'b1);

        // Reset lands while fill address 4 is in its setup cycle.
        base_q = en_q.size();
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b10; req_addr = 8'h00; req_wdata = 8'h33;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("fill4_setup_addr", mem_addr, 4);
        check("fill4_setup_en", mem_en, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_mem_en", mem_en, 0);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_rsp_valid", rsp_valid, 0);
        @(negedge clk); rst = 1'b0;
        check("midrst_pulses", en_q.size() - base_q, 4);
        for (int i = 0; i < 4; i++) ref_mem[i] = 8'h33;
        for (int i = 0; i < DEPTH; i++) do_cmd(2'b00, 8'(i), 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
